// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue
//   Buffered instruction decoder between fetch and register-read. Raw
//   instructions (with PC) enter through a valid/ready handshake, wait in a
//   DEPTH-entry FIFO, are decoded at the head and are held in an output
//   register presented with valid/ready. When the FIFO is empty and the output
//   register is free, an incoming instruction goes straight into the output
//   register, so the total capacity is DEPTH+1.
//
//   Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//     defined   : an unrecognised opcode raises out_illegal and halts intake
//                 until flush.
//     undefined : out_illegal is 0 and unrecognised opcodes flow through as
//                 op 000000.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   flush                 discard buffered and registered instructions
//   in_valid/in_ready     input handshake
//   in_instr, in_pc       raw instruction and its PC
//   out_valid/out_ready   output handshake
//   out_op                6-bit operation encoding
//   out_rs1/rs2/rd        register indices
//   out_imm, out_use_imm  sign-extended immediate, operand-2-is-immediate
//   out_pc                PC passthrough
//   out_illegal           unrecognised opcode (trap build only)
// -----------------------------------------------------------------------------
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_op,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_use_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic [0:0] ST_HALT = 1'b1;
`endif

    // FIFO storage (small, read combinationally so the head can be decoded
    // in the same cycle it is popped)
    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [0:0]    state_q, state_d;

    logic            out_valid_q;
    logic [5:0]      out_op_q;
    logic [4:0]      out_rs1_q, out_rs2_q, out_rd_q;
    logic [XLEN-1:0] out_imm_q, out_pc_q;
    logic            out_use_imm_q, out_illegal_q;

    logic push, load_out, bypass, fifo_wr, fifo_rd;
    logic [31:0]     src_instr;
    logic [XLEN-1:0] src_pc;

    assign in_ready = (count_q < CW'(DEPTH)) && (state_q == ST_RUN) && !flush;
    assign push     = in_valid && in_ready;
    assign bypass   = (count_q == '0);
    // The output register takes a new instruction whenever one is available
    // (queued head, or the input itself when the queue is empty) and the
    // register is free or being drained this cycle.
    assign load_out = (!bypass || push) && (!out_valid_q || out_ready) &&
                      (state_q == ST_RUN) && !flush;
    assign fifo_wr  = push && !(bypass && load_out);
    assign fifo_rd  = load_out && !bypass;

    assign src_instr = bypass ? in_instr : instr_mem[rd_ptr_q];
    assign src_pc    = bypass ? in_pc    : pc_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            instr_mem[wr_ptr_q] <= in_instr;
            pc_mem[wr_ptr_q]    <= in_pc;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(fifo_wr);
        rd_ptr_d = rd_ptr_q + AW'(fifo_rd);
        count_d  = count_q + CW'(fifo_wr) - CW'(fifo_rd);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ---------------- decode of the selected head ----------------
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
    logic [5:0]      dec_op;
    logic [XLEN-1:0] dec_imm;
    logic            dec_use_imm, dec_illegal;

    assign opc   = src_instr[6:0];
    assign f3    = src_instr[14:12];
    assign imm_i = {{(XLEN-12){src_instr[31]}}, src_instr[31:20]};
    assign imm_s = {{(XLEN-12){src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
    assign imm_b = {{(XLEN-13){src_instr[31]}}, src_instr[31], src_instr[7],
                    src_instr[30:25], src_instr[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){src_instr[31]}}, src_instr[31], src_instr[19:12],
                    src_instr[20], src_instr[30:21], 1'b0};
    // bit 31 of the U value is instr[31], so replicating it covers XLEN=32 too
    assign imm_u = {{(XLEN-31){src_instr[31]}}, src_instr[30:12], 12'b0};

    generate
        if (XLEN > 32) begin : g_shamt6
            assign imm_sh = {{(XLEN-6){1'b0}}, src_instr[25:20]};
        end else begin : g_shamt5
            assign imm_sh = {{(XLEN-5){1'b0}}, src_instr[24:20]};
        end
    endgenerate

    always_comb begin
        dec_op      = 6'b000000;
        dec_imm     = '0;
        dec_use_imm = 1'b0;
        dec_illegal = 1'b0;
        if (src_instr == 32'h0) begin
            // all-zero word decodes as the null op
        end else if (opc[4] && !opc[2]) begin
            dec_op[5]   = opc[5];
            dec_op[3]   = 1'b1;
            dec_op[2:0] = f3;
            if (opc[5]) begin
                dec_op[4] = src_instr[30];
            end else if (f3[1:0] == 2'b01) begin
                dec_op[4]   = src_instr[30];
                dec_imm     = imm_sh;
                dec_use_imm = 1'b1;
            end else begin
                dec_imm     = imm_i;
                dec_use_imm = 1'b1;
            end
        end else if (!opc[6] && !opc[4]) begin
            dec_op      = {opc[5], 2'b10, f3};
            dec_imm     = opc[5] ? imm_s : imm_i;
            dec_use_imm = 1'b1;
        end else if (opc == 7'b1100011) begin
            dec_op  = {3'b100, f3};
            dec_imm = imm_b;
        end else if (opc == 7'b1100111) begin
            dec_op      = 6'b000100;
            dec_imm     = imm_i;
            dec_use_imm = 1'b1;
        end else if (opc == 7'b1101111) begin
            dec_op  = 6'b000101;
            dec_imm = imm_j;
        end else if (opc == 7'b0010111 || opc == 7'b0110111) begin
            dec_op      = {3'b000, opc[5:3]};
            dec_imm     = imm_u;
            dec_use_imm = 1'b1;
        end else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            dec_illegal = 1'b1;
`endif
        end
    end

    // ---------------- run / halt state ----------------
    always_comb begin
        state_d = state_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (flush)
            state_d = ST_RUN;
        else if (load_out && dec_illegal)
            state_d = ST_HALT;
`else
        state_d = ST_RUN;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_op_q      <= '0;
            out_rs1_q     <= '0;
            out_rs2_q     <= '0;
            out_rd_q      <= '0;
            out_imm_q     <= '0;
            out_use_imm_q <= 1'b0;
            out_pc_q      <= '0;
            out_illegal_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (load_out) begin
            out_valid_q   <= 1'b1;
            out_op_q      <= dec_op;
            out_rs1_q     <= src_instr[19:15];
            out_rs2_q     <= src_instr[24:20];
            out_rd_q      <= src_instr[11:7];
            out_imm_q     <= dec_imm;
            out_use_imm_q <= dec_use_imm;
            out_pc_q      <= src_pc;
            out_illegal_q <= dec_illegal;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op      = out_op_q;
    assign out_rs1     = out_rs1_q;
    assign out_rs2     = out_rs2_q;
    assign out_rd      = out_rd_q;
    assign out_imm     = out_imm_q;
    assign out_use_imm = out_use_imm_q;
    assign out_pc      = out_pc_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised, buffered successor to the single-cycle instruction decoder. It accepts raw instructions with their PC through a valid/ready handshake and holds them in a DEPTH-entry FIFO. It decodes the FIFO head into the team's 6-bit op encoding, register indices and a sign-extended immediate, and presents the result from an output register with valid/ready. It sits between fetch and register-read/execute in the pipelined core.

## Interface
- XLEN, 32: datapath width; immediates and PC are XLEN bits (32 or 64).
- DEPTH, 4: FIFO entries, power of two, ≥2.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard all buffered and registered instructions.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decoded instruction present.
- out_ready  in  1  consumer takes it.
- out_op  out  6  operation encoding.
- out_rs1, out_rs2, out_rd  out  5 each  register indices, instr[19:15], [24:20], [11:7].
- out_imm  out  XLEN  sign-extended immediate.
- out_use_imm  out  1  operand 2 is out_imm, not rs2 value.
- out_pc  out  XLEN  PC passthrough.
- out_illegal  out  1  unrecognised opcode.

## Operation
- Push when in_valid&&in_ready. Pop the head into the output register when the head exists and (!out_valid || out_ready).
- Op encoding:
  - instr==0 → op 000000, imm 0, use_imm 0.
  - ALU (opcode[4,2]=10) → op[3]=1; op[5]=opcode[5]; op[2:0]=funct3.
    - Reg form: op[4]=funct7[5], use_imm 0.
    - Shift-imm (funct3[1:0]=01): op[4]=funct7[5], imm=zero-extended shamt.
    - Other imm forms: op[4]=0, imm=I-type.
  - Load/store ({opcode[6],opcode[4]}=00) → op[4:3]=10; op[5]=opcode[5]; op[2:0]=funct3; use_imm 1; imm I-type (load) or S-type (store).
  - Branch (opcode 1100011) → op[5:3]=100; op[2:0]=funct3; imm B-type; use_imm 0.
  - JALR/JAL/AUIPC/LUI → op[5:3]=000; op[2:0]=opcode[5:3] (100/101/010/110).
    - JALR: imm I-type, use_imm 1.
    - JAL: imm J-type.
    - AUIPC/LUI: imm U-type.
- Any other opcode is illegal.
- All immediates sign-extend from instr[31] to XLEN. U-type is {instr[31:12],12'b0} then sign-extended.
- State machine: RUN, HALT.
  - RUN → HALT when an illegal instruction is loaded into the output register (macro only).
  - HALT → RUN on flush or reset.

## Timing
- Reset: FIFO empty, count 0, state RUN. out_valid, out_illegal, out_use_imm = 0; out_op, out_rs*, out_rd, out_imm, out_pc = 0. in_ready = 1.
- Latency: an instruction pushed into an empty block at cycle N has out_valid=1 at N+1.
- Throughput is one instruction per cycle. Total capacity is DEPTH+1.
- in_ready = (count<DEPTH) && state==RUN && !flush. There is no same-cycle push-through at full.
- Output fields hold stable while out_valid && !out_ready.
- Flush takes priority over push and pop. Next cycle: count=0, out_valid=0, state=RUN. Offered in_instr that cycle is dropped.
- Read and write pointers wrap modulo DEPTH. Push and pop in the same cycle leave count unchanged.
- Reset mid-stream behaves as flush and also zeros all output fields.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined:
  - Illegal opcode → out_illegal=1, out_op=0, imm=0.
  - The block enters HALT. in_ready=0 until flush; queued entries remain but are not popped.
- Undefined:
  - out_illegal tied 0.
  - Illegal opcode decodes as op 000000 and flows through. The state machine stays RUN.

## Test plan
- XLEN=32, push 0xFFF10093 (addi x1,x2,-1), out_ready=1 → next cycle out_valid=1, op=001000, rs1=2, rd=1, imm=0xFFFFFFFF, use_imm=1.
- Push 0x402081B3 (sub x3,x1,x2) → op=111000, rs1=1, rs2=2, rd=3, use_imm=0.
- Push 0xFE208EE3 (beq x1,x2,-4) with in_pc=0x100 → op=100000, imm=0xFFFFFFFC, out_pc=0x100. With XLEN=64, imm=0xFFFFFFFFFFFFFFFC.
- DEPTH=2, out_ready=0, in_valid held with 4 instructions:
  - 3 accepted, then in_ready=0.
  - Raise out_ready: outputs appear in order, one per cycle.
  - in_ready returns 1 the cycle after the first pop.
- Mid-stream flush with 2 queued → next cycle out_valid=0, in_ready=1, and no flushed instruction ever appears.
- With DECODE_ILLEGAL_TRAP_EN, push 0xFFFFFFFF then 0x00000013:
  - out_illegal=1 and in_ready stays 0.
  - After flush, 0x00000013 must be re-pushed to appear.
  - Without the macro, both flow through with op 000000 then 001000.
